// File: rtl/uart_rx_core.sv
// UART serial receiver with 2-flop input synchronizer and one-word holding register.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around each mid-bit sample.
module uart_rx_core #(
   parameter int C_CLK_FRQ         = 100000000,
   parameter int C_UART_RATE       = 1000000,
   parameter int C_UART_DATA_WIDTH = 8,
   parameter int C_UART_PARITY     = 0,
   parameter int C_UART_STOP       = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rx,
   output logic [C_UART_DATA_WIDTH-1:0] data,
   output logic                         valid,
   input  logic                         ready,
   output logic                         busy,
   output logic                         frm_err,
   output logic                         par_err,
   output logic                         ovr
);

   localparam int C_DIV = (C_CLK_FRQ + C_UART_RATE / 2) / C_UART_RATE;
   localparam int CW    = $clog2(C_DIV);
   localparam int BW    = $clog2(C_UART_DATA_WIDTH + 1);
   localparam int W     = C_UART_DATA_WIDTH;

`ifdef UART_RX_MAJORITY_EN
   // Vote completes one clk after mid-bit; later bits inherit the shift.
   localparam int START_PT = C_DIV / 2;
`else
   localparam int START_PT = C_DIV / 2 - 1;
`endif

   localparam logic [CW-1:0] START_LAST = CW'(START_PT);
   localparam logic [CW-1:0] BIT_LAST   = CW'(C_DIV - 1);
   localparam logic [BW-1:0] DATA_LAST  = BW'(W - 1);
   localparam logic          STOP_LAST  = 1'(C_UART_STOP - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   logic [1:0]    sync_q;
   logic          prev_q;
   logic          rx_s;
   logic          smp;
   logic          fall;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] bit_q, bit_d;
   logic          stp_q, stp_d;
   logic [W-1:0]  word_q, word_d;
   logic          perr_q, perr_d;

   logic [W-1:0]  data_q;
   logic          valid_q;
   logic          frm_q, frm_d;
   logic          par_q, par_d;
   logic          ovr_q;
   logic          commit;

   assign rx_s = sync_q[1];
   assign fall = ~rx_s & prev_q;

`ifdef UART_RX_MAJORITY_EN
   logic prev2_q;

   // Second history flop feeding the 2-of-3 vote.
   always_ff @(posedge clk) begin
      if (rst) prev2_q <= 1'b1;
      else     prev2_q <= prev_q;
   end

   assign smp = (rx_s & prev_q) | (rx_s & prev2_q) | (prev_q & prev2_q);
`else
   assign smp = rx_s;
`endif

   // Metastability synchronizer plus one history flop for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], rx};
         prev_q <= rx_s;
      end
   end

   // Frame FSM and bit-timing state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         stp_q   <= 1'b0;
         word_q  <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         stp_q   <= stp_d;
         word_q  <= word_d;
         perr_q  <= perr_d;
      end
   end

   // Next-state: walk the frame, sampling at each bit's centre.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      stp_d   = stp_q;
      word_d  = word_q;
      perr_d  = perr_q;
      frm_d   = 1'b0;
      par_d   = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (fall) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == START_LAST) begin
               cnt_d = '0;
               if (smp) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  bit_d   = '0;
                  perr_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d  = '0;
               word_d = {smp, word_q[W-1:1]};
               if (bit_q == DATA_LAST) begin
                  state_d = (C_UART_PARITY != 0) ? S_PARITY : S_STOP;
                  stp_d   = 1'b0;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_PARITY: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               perr_d  = smp ^ (^word_q);
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (!smp) begin
                  frm_d   = 1'b1;
                  par_d   = perr_q;
                  state_d = S_WAIT_HIGH;
               end else if (stp_q == STOP_LAST) begin
                  par_d   = perr_q;
                  commit  = ~perr_q;
                  state_d = S_IDLE;
               end else begin
                  stp_d = ~stp_q;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT_HIGH: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Holding register, handshake and error strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         frm_q   <= 1'b0;
         par_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         frm_q <= frm_d;
         par_q <= par_d;
         ovr_q <= 1'b0;
         if (commit) begin
            data_q  <= word_q;
            valid_q <= 1'b1;
            ovr_q   <= valid_q & ~ready;
         end else if (valid_q && ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign data    = data_q;
   assign valid   = valid_q;
   assign busy    = (state_q != S_IDLE);
   assign frm_err = frm_q;
   assign par_err = par_q;
   assign ovr     = ovr_q;

endmodule
